reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit asynchronously-reset storage register between NREQ write requesters.
- Sequences grant, write and release so that at most one requester updates the register per cycle.
- Sits between the requesting datapath blocks and the shared register; the stored value is broadcast on q.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, register data width.
- MAX_HOLD, 8, maximum consecutive locked grant cycles (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req  input  NREQ  per-requester write request; level, held until granted.
- wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant; registered.
- wr_done  output  1  one-cycle pulse, the cycle after a write commits.
- owner  output  $clog2(NREQ)  index of the current or last granted requester.
- busy  output  1  high while in state GRANT.
- q  output  WIDTH  shared register contents.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-grant):
  - q=0, gnt=0, wr_done=0, owner=0, busy=0.
  - Round-robin pointer ptr=0; state=IDLE.
- State IDLE:
  - If any req bit is high, select the first i with req[i]=1, searching ptr, ptr+1, … modulo NREQ.
  - Next edge: gnt=onehot(i), owner=i, state=GRANT.
  - If no req is high, stay in IDLE with gnt=0.
- State GRANT (gnt[owner]=1):
  - At the edge:
    - If req[owner]=1: q<=wdata[owner], and wr_done=1 next cycle.
    - If req[owner]=0 (request withdrawn): no write, and wr_done stays 0.
  - In both cases ptr<=owner+1 mod NREQ.
  - Next-state decision at the same edge, using the updated pointer and excluding owner from the search:
    - If another requester is pending, issue the new grant back-to-back and stay in GRANT.
    - Otherwise gnt=0 and state=IDLE.
    - If the only pending request is owner itself, it is re-granted only after one IDLE cycle (fairness).
- Latency: req rising in IDLE → gnt the next cycle → q updated at the following edge → wr_done one cycle after that.
- Grant duration: without the optional feature, a grant lasts exactly one cycle.
- Pointer wrap: when owner=NREQ-1, ptr wraps to 0.
- Simultaneous requests: resolved strictly by pointer order, never by fixed priority.
- Invariants:
  - gnt is always one-hot or zero.
  - busy equals |gnt.
- Unused bits: wdata of non-granted requesters is ignored.

Optional Feature:
- Macro: REGARB_LOCK_EN.
- When defined:
  - Adds port lock (input, NREQ).
  - In GRANT, if lock[owner]=1 and req[owner]=1, the grant is held and q is written every cycle.
  - The hold lasts at most MAX_HOLD consecutive cycles. On that cycle the grant is force-released and ptr advances.
  - A hold counter of width $clog2(MAX_HOLD+1) resets to 0 on every new grant.
  - Dropping lock releases the grant at the next edge.
- When undefined:
  - The lock port and hold counter do not exist.
  - Grants are always a single cycle.

Decomposition:
- Shared package regarb_pkg holds:
  - state typedef (IDLE, GRANT);
  - localparam REGARB_PTR_W function or constant;
  - default WIDTH/NREQ constants.
- Sub-module shared_reg: WIDTH-bit register with asynchronous active-low reset (clear to 0) and write enable. The arbiter instantiates it for q.
- The round-robin select is a combinational function inside the arbiter and is not a separate module.

Test Plan:
- Reset: assert rst=0 mid-grant (gnt=4'b0100, q=4'hA) → gnt, q, wr_done and owner go to 0 immediately, without waiting for a clock edge; state IDLE after release.
- Single requester: req=4'b0001, wdata[0]=4'h5 → gnt=0001 at cycle 1, q=5 at cycle 2, wr_done pulse at cycle 3.
- All requesting: req=4'b1111, data 1,2,3,4, ptr=0 → grants 0,1,2,3 back-to-back, q sequence 1,2,3,4; then ptr=0 (wrap).
- Withdrawal: req[2] is granted but dropped in the grant cycle → q unchanged, no wr_done, ptr=3.
- Fairness: req[1] held continuously with req[3] → grants alternate 1,3,1,3; requester 1 is never granted twice in a row while req[3]=1.
- With REGARB_LOCK_EN: lock[0]=1 and req[0]=1 for 20 cycles, MAX_HOLD=8 → gnt[0] held for 8 cycles, released, and pending req[1] is granted next.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the round-robin register write arbiter.
package regarb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } regarb_state_e;

    localparam int REGARB_NREQ_DEF     = 4;
    localparam int REGARB_WIDTH_DEF    = 4;
    localparam int REGARB_MAX_HOLD_DEF = 8;

    function automatic int regarb_ptr_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the register write arbiter; the lock vector exists only
// when REGARB_LOCK_EN is defined.
interface reg_write_arbiter_if
    import regarb_pkg::*;
#(
    parameter int NREQ  = REGARB_NREQ_DEF,
    parameter int WIDTH = REGARB_WIDTH_DEF
);
    localparam int PTR_W = regarb_ptr_w(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic                  wr_done;
    logic [PTR_W-1:0]      owner;
    logic                  busy;
    logic [WIDTH-1:0]      q;
`ifdef REGARB_LOCK_EN
    logic [NREQ-1:0]       lock;

    modport master (output req, wdata, lock, input gnt, wr_done, owner, busy, q);
    modport slave  (input req, wdata, lock, output gnt, wr_done, owner, busy, q);
`else
    modport master (output req, wdata, input gnt, wr_done, owner, busy, q);
    modport slave  (input req, wdata, output gnt, wr_done, owner, busy, q);
`endif

endinterface

// File: rtl/reg_write_arbiter_shared_reg.sv
// Shared storage register: asynchronous active-low clear, synchronous write enable.
module shared_reg
    import regarb_pkg::*;
#(
    parameter int WIDTH = REGARB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Storage element, loaded only when the arbiter commits a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= {WIDTH{1'b0}};
        end else if (we_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register among NREQ writers.
// Optional grant locking with a MAX_HOLD bound is enabled by REGARB_LOCK_EN.
module reg_write_arbiter
    import regarb_pkg::*;
#(
    parameter int NREQ     = REGARB_NREQ_DEF,
    parameter int WIDTH    = REGARB_WIDTH_DEF,
    parameter int MAX_HOLD = REGARB_MAX_HOLD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    reg_write_arbiter_if.slave bus
);

    localparam int               PTR_W    = regarb_ptr_w(NREQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1) begin : g_param_check
        $error("reg_write_arbiter: NREQ must be 2..8 and MAX_HOLD at least 1");
    end

    regarb_state_e    state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             commit_q, commit_d;
    logic             wr_done_q;
    logic             we_s;
    logic             hold_s;
    logic [WIDTH-1:0] wdata_sel_s;
    logic [WIDTH-1:0] q_s;
    logic [PTR_W-1:0] ptr_next_s;
    logic [PTR_W:0]   pick_idle_s;
    logic [PTR_W:0]   pick_next_s;

    // Returns {found, index} of the first set bit at or after start, modulo NREQ.
    function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [PTR_W-1:0] start);
        logic [PTR_W:0] res;
        int             idx;
        res = {(PTR_W + 1){1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NREQ;
            if (r[idx]) begin
                res = {1'b1, PTR_W'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] i);
        return {{(NREQ - 1){1'b0}}, 1'b1} << i;
    endfunction

    assign wdata_sel_s = bus.wdata[owner_q*WIDTH +: WIDTH];
    assign ptr_next_s  = (owner_q == LAST_IDX) ? {PTR_W{1'b0}} : owner_q + 1'b1;
    assign pick_idle_s = rr_pick(bus.req, ptr_q);
    // In GRANT, gnt_q masks the current owner so it cannot win back-to-back.
    assign pick_next_s = rr_pick(bus.req & ~gnt_q, ptr_next_s);

`ifdef REGARB_LOCK_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign hold_s = (state_q == GRANT) && bus.lock[owner_q] && bus.req[owner_q]
                    && (hold_q < HOLD_W'(MAX_HOLD - 1));

    // Hold counter: counts extra cycles of a locked grant, cleared otherwise.
    always_comb begin
        hold_d = {HOLD_W{1'b0}};
        if (hold_s) begin
            hold_d = hold_q + 1'b1;
        end else begin
            hold_d = {HOLD_W{1'b0}};
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= {HOLD_W{1'b0}};
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_s = 1'b0;
`endif

    // Next-state, grant selection and write enable.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gnt_d    = {NREQ{1'b0}};
        we_s     = 1'b0;
        commit_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_idle_s[PTR_W]) begin
                    state_d = GRANT;
                    owner_d = pick_idle_s[PTR_W-1:0];
                    gnt_d   = onehot(pick_idle_s[PTR_W-1:0]);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                we_s     = bus.req[owner_q];
                commit_d = bus.req[owner_q];
                if (hold_s) begin
                    gnt_d = gnt_q;
                end else if (pick_next_s[PTR_W]) begin
                    ptr_d   = ptr_next_s;
                    owner_d = pick_next_s[PTR_W-1:0];
                    gnt_d   = onehot(pick_next_s[PTR_W-1:0]);
                end else begin
                    ptr_d   = ptr_next_s;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state and registered outputs; wr_done trails the commit by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= {PTR_W{1'b0}};
            owner_q   <= {PTR_W{1'b0}};
            gnt_q     <= {NREQ{1'b0}};
            commit_q  <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            commit_q  <= commit_d;
            wr_done_q <= commit_q;
        end
    end

    shared_reg #(.WIDTH(WIDTH)) u_shared_reg (
        .clk  (clk),
        .rst  (rst),
        .we_i (we_s),
        .d_i  (wdata_sel_s),
        .q_o  (q_s)
    );

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state_q == GRANT);
    assign bus.wr_done = wr_done_q;
    assign bus.q       = q_s;

endmodule
